// File: rtl/fetch_pkg.sv
// Shared definitions for the MIPS fetch stage: run-control state encodings,
// the NOP word and the default instruction-memory depth.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
    localparam int          IMEM_WORDS_DEF = 32;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage control: resolves redirect > stall > run-control action each
// cycle and decides whether the IF/ID register issues, bubbles or holds.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int IMEM_WORDS = IMEM_WORDS_DEF,
    parameter int PC_W       = 32
) (
    input  fetch_state_e    state,
    input  logic [PC_W-1:0] pc,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            dbg_run,
    input  logic            dbg_step,
    input  logic            dbg_pause,
    output logic            issue,
    output logic            bubble,
    output logic            hold,
    output logic            load_redirect,
    output fetch_state_e    next_state
);

    logic w_last;
    logic w_target_oob;

    assign w_last       = (pc == PC_W'(IMEM_WORDS - 1));
    assign w_target_oob = (redirect_pc >= PC_W'(IMEM_WORDS));

    always_comb begin
        issue         = 1'b0;
        bubble        = 1'b0;
        hold          = 1'b0;
        load_redirect = 1'b0;
        next_state    = state;

        if (redirect && state != ST_IDLE) begin
            load_redirect = 1'b1;
            bubble        = 1'b1;
            if (w_target_oob)
                next_state = ST_DONE;
            else if (state == ST_DONE)
                next_state = ST_RUN;
        end else if (stall) begin
            // debug pulses arriving here are intentionally lost
            hold = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE, ST_PAUSE: begin
                    if (dbg_pause) begin
                        bubble = 1'b1;
                    end else if (dbg_step) begin
                        issue      = 1'b1;
                        next_state = w_last ? ST_DONE : ST_PAUSE;
                    end else if (dbg_run) begin
                        bubble     = 1'b1;
                        next_state = ST_RUN;
                    end else begin
                        bubble = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (dbg_pause) begin
                        bubble     = 1'b1;
                        next_state = ST_PAUSE;
                    end else begin
                        issue = 1'b1;
                        if (w_last)
                            next_state = ST_DONE;
                    end
                end
                default: begin
                    bubble = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: owns the PC, the IF/ID pipeline register and the issue
// counter; all sequencing decisions come from fetch_ctrl.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int IMEM_WORDS = IMEM_WORDS_DEF,
    parameter int PC_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_in,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            dbg_run,
    input  logic            dbg_step,
    input  logic            dbg_pause,
    output logic [PC_W-1:0] pc_out,
    output logic [31:0]     if_id_instr,
    output logic [PC_W-1:0] if_id_pc1,
    output logic            if_id_valid,
    output logic [1:0]      state_out,
    output logic [31:0]     fetch_count
);

    fetch_state_e    r_state;
    fetch_state_e    w_next_state;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [PC_W-1:0] r_pc1;
    logic            r_valid;
    logic [31:0]     r_count;
    logic            w_issue;
    logic            w_bubble;
    logic            w_hold;
    logic            w_load_redirect;

    fetch_ctrl #(
        .IMEM_WORDS (IMEM_WORDS),
        .PC_W       (PC_W)
    ) u_ctrl (
        .state         (r_state),
        .pc            (r_pc),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .dbg_run       (dbg_run),
        .dbg_step      (dbg_step),
        .dbg_pause     (dbg_pause),
        .issue         (w_issue),
        .bubble        (w_bubble),
        .hold          (w_hold),
        .load_redirect (w_load_redirect),
        .next_state    (w_next_state)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
            r_pc1   <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else if (!w_hold) begin
            r_state <= w_next_state;
            if (w_issue) begin
                r_instr <= instr_in;
                r_valid <= 1'b1;
                r_pc1   <= r_pc + PC_W'(1);
                r_pc    <= r_pc + PC_W'(1);
                r_count <= r_count + 32'd1;
            end
            if (w_bubble) begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
                r_pc1   <= '0;
            end
            if (w_load_redirect)
                r_pc <= redirect_pc;
        end
    end

    assign pc_out      = r_pc;
    assign if_id_instr = r_instr;
    assign if_id_pc1   = r_pc1;
    assign if_id_valid = r_valid;
    assign state_out   = r_state;
    assign fetch_count = r_count;

endmodule
